// File: rtl/adder_mp_seq.sv
// Multi-precision add sequencer: WORDS*32-bit operands pass one word per clock through a shared
// 32-bit lookahead adder, LSW first. Define ADDER_MP_SUB_EN to add the in_sub (subtract) mode.

module adder_la32bit (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o
);
   logic [31:0] g, p;
   logic [32:0] c;
   logic [7:0]  grp_g, grp_p;
   logic [8:0]  grp_c;

   // Eight 4-bit groups: group generate/propagate drive a lookahead chain across groups,
   // and bits inside a group take their carry from the group carry-in.
   always_comb begin
      g     = a_i & b_i;
      p     = a_i ^ b_i;
      grp_g = '0;
      grp_p = '0;
      grp_c = '0;
      c     = '0;
      for (int k = 0; k < 8; k++) begin
         grp_g[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         grp_p[k] = &p[4*k +: 4];
      end
      grp_c[0] = cin_i;
      for (int k = 0; k < 8; k++) begin
         grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
      end
      for (int k = 0; k < 8; k++) begin
         c[4*k] = grp_c[k];
         for (int j = 0; j < 3; j++) begin
            c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
         end
      end
      c[32] = grp_c[8];
   end

   assign sum_o  = p ^ c[31:0];
   assign cout_o = c[32];
endmodule

module adder_mp_seq #(
   parameter int WORDS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*WORDS-1:0] in_op1,
   input  logic [32*WORDS-1:0] in_op2,
   input  logic                in_cin,
`ifdef ADDER_MP_SUB_EN
   input  logic                in_sub,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*WORDS-1:0] out_sum,
   output logic                out_cout,
   output logic                busy
);
   localparam int W     = 32 * WORDS;
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       sum_q, sum_d;
   logic               cout_q, cout_d;
   logic [W-1:0]       op1_q, op2_q;
   logic               sub_q;
   logic               accept;
   logic               start_carry;
   logic [31:0]        add_a, add_b, add_sum;
   logic               add_cout;

   assign accept = (state_q == S_IDLE) && in_valid;

`ifdef ADDER_MP_SUB_EN
   assign start_carry = in_sub ? 1'b1 : in_cin;
   assign add_b       = sub_q ? ~op2_q[idx_q*32 +: 32] : op2_q[idx_q*32 +: 32];
`else
   assign start_carry = in_cin;
   assign add_b       = op2_q[idx_q*32 +: 32];
`endif
   assign add_a = op1_q[idx_q*32 +: 32];

   adder_la32bit u_adder (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (carry_q),
      .sum_o  (add_sum),
      .cout_o (add_cout)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               idx_d   = '0;
               carry_d = start_carry;
               sum_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[idx_q*32 +: 32] = add_sum;
            carry_d               = add_cout;
            idx_d                 = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(WORDS - 1)) begin
               cout_d  = add_cout;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // NOTE: operand holding registers need no reset; they are only read after an accept loads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         op1_q <= in_op1;
         op2_q <= in_op2;
`ifdef ADDER_MP_SUB_EN
         sub_q <= in_sub;
`else
         sub_q <= 1'b0;
`endif
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
endmodule

// File: tb/tb_adder_mp_seq.sv
// Directed self-checking bench for adder_mp_seq (WORDS=4); covers ADDER_MP_SUB_EN when defined.

module tb_adder_mp_seq;
   localparam int WORDS = 4;
   localparam int W     = 32 * WORDS;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_op1;
   logic [W-1:0] in_op2;
   logic         in_cin;
   logic         in_sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         busy;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   adder_mp_seq #(.WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op1    (in_op1),
      .in_op2    (in_op2),
      .in_cin    (in_cin),
`ifdef ADDER_MP_SUB_EN
      .in_sub    (in_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .busy      (busy)
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Called #1 after an edge with the DUT idle; returns #1 after the edge that returns it to idle.
   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] exp_sum, input logic exp_cout);
      in_op1   = a;
      in_op2   = b;
      in_cin   = ci;
      in_valid = 1'b1;
      check({tag, " in_ready idle"}, W'(in_ready), W'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_op1   = ~a;
      in_op2   = ~b;
      in_cin   = ~ci;
      check({tag, " busy run"}, W'(busy), W'(1));
      check({tag, " in_ready run"}, W'(in_ready), W'(0));
      for (int k = 1; k < WORDS; k++) begin
         @(posedge clk); #1;
         check({tag, " early valid"}, W'(out_valid), W'(0));
      end
      @(posedge clk); #1;
      check({tag, " valid"}, W'(out_valid), W'(1));
      check({tag, " sum"}, out_sum, exp_sum);
      check({tag, " cout"}, W'(out_cout), W'(exp_cout));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " valid drop"}, W'(out_valid), W'(0));
      check({tag, " ready back"}, W'(in_ready), W'(1));
      check({tag, " sum held"}, out_sum, exp_sum);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op1    = '0;
      in_op2    = '0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b0;
      #2;
      check("rst valid", W'(out_valid), W'(0));
      check("rst ready", W'(in_ready), W'(1));
      check("rst busy", W'(busy), W'(0));
      check("rst sum", out_sum, '0);
      check("rst cout", W'(out_cout), W'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("t1", W'(7), W'(7), 1'b0, W'(14), 1'b0);
      run_op("t2", {W{1'b1}}, W'(1), 1'b0, '0, 1'b1);
      run_op("t3a", {WORDS{32'hF0F0F0F0}}, {WORDS{32'h0F0F0F0F}}, 1'b1, '0, 1'b1);
      run_op("t3b", W'(7), W'(7), 1'b1, W'(15), 1'b0);
      run_op("mid", {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF}, W'(1), 1'b0,
             {32'h0, 32'h1, 32'h0, 32'h0}, 1'b0);

      // Backpressure in DONE, with a competing request held throughout.
      in_op1   = W'(32'h10);
      in_op2   = W'(32'h20);
      in_cin   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_op1 = W'(1);
      in_op2 = W'(2);
      repeat (WORDS) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check("t4 hold valid", W'(out_valid), W'(1));
         check("t4 hold sum", out_sum, W'(32'h30));
         check("t4 hold ready", W'(in_ready), W'(0));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t4 release valid", W'(out_valid), W'(0));
      check("t4 release ready", W'(in_ready), W'(1));
      check("t4 not yet busy", W'(busy), W'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("t4 second accept", W'(busy), W'(1));
      repeat (WORDS) @(posedge clk);
      #1;
      check("t4 second valid", W'(out_valid), W'(1));
      check("t4 second sum", out_sum, W'(3));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset with idx=2 in RUN.
      in_op1   = {W{1'b1}};
      in_op2   = {W{1'b1}};
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("t5 rst valid", W'(out_valid), W'(0));
      check("t5 rst sum", out_sum, '0);
      check("t5 rst ready", W'(in_ready), W'(1));
      check("t5 rst busy", W'(busy), W'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 0; k < WORDS + 1; k++) begin
         @(posedge clk); #1;
         check("t5 no pulse", W'(out_valid), W'(0));
      end
      run_op("t5", W'(5), W'(3), 1'b0, W'(8), 1'b0);

`ifdef ADDER_MP_SUB_EN
      in_sub = 1'b1;
      run_op("t6a", W'(5), W'(7), 1'b0, {{(W-4){1'b1}}, 4'hE}, 1'b0);
      run_op("t6b", W'(7), W'(5), 1'b0, W'(2), 1'b1);
      in_sub = 1'b0;
      run_op("t6c", W'(7), W'(5), 1'b0, W'(12), 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
